// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns a cmd stream into one AW/W/B or AR/R
// transaction at a time, with a saturating busy-time watchdog and a sticky protocol monitor.
module axil_cmd_master #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  output logic                      proto_err,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RD, S_RR, S_RSP} state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  state_t                    r_state;
  logic                      r_cmd_ready, r_awvalid, r_wvalid, r_bready;
  logic                      r_arvalid, r_rready, r_rsp_valid;
  logic                      r_aw_done, r_w_done;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata, r_rdata;
  logic [DATA_WIDTH/8-1:0]   r_wstrb;
  logic [1:0]                r_resp;
  logic                      r_rsp_timeout, r_proto_err, r_to_flag;
  logic [15:0]               r_tcnt;

  logic        w_aw_hs, w_w_hs, w_ar_hs, w_aw_done, w_w_done;
  logic        w_busy, w_to_hit, w_b_err, w_r_err;
  logic [15:0] w_tcnt_nxt;

  assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs    = r_wvalid & M_AXI_WREADY;
  assign w_ar_hs   = r_arvalid & M_AXI_ARREADY;
  assign w_aw_done = r_aw_done | w_aw_hs;
  assign w_w_done  = r_w_done | w_w_hs;

  assign w_busy     = (r_state == S_WR) || (r_state == S_WB) ||
                      (r_state == S_RD) || (r_state == S_RR);
  assign w_tcnt_nxt = (r_tcnt == 16'hFFFF) ? r_tcnt : r_tcnt + 16'd1;
  assign w_to_hit   = r_to_flag | (w_busy & (w_tcnt_nxt >= TO_LIM));

  // A response is legal only once its request handshake(s) have completed, this cycle included
  assign w_b_err = M_AXI_BVALID &
                   ~((r_state == S_WB) || ((r_state == S_WR) && w_aw_done && w_w_done));
  assign w_r_err = M_AXI_RVALID &
                   ~((r_state == S_RR) || ((r_state == S_RD) && w_ar_hs));

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_rdata       <= '0;
      r_resp        <= 2'b00;
      r_rsp_timeout <= 1'b0;
      r_proto_err   <= 1'b0;
      r_to_flag     <= 1'b0;
      r_tcnt        <= 16'd0;
    end else begin
      if (w_b_err || w_r_err) r_proto_err <= 1'b1;
      if (w_busy) begin
        r_tcnt <= w_tcnt_nxt;
        if (w_to_hit) r_to_flag <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= cmd_addr;
            r_tcnt      <= 16'd0;
            r_to_flag   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            if (cmd_we) begin
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_WR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WB;
          end
        end
        S_WB: begin
          if (M_AXI_BVALID) begin
            r_bready      <= 1'b0;
            r_resp        <= M_AXI_BRESP;
            r_rdata       <= '0;
            r_rsp_timeout <= w_to_hit;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RSP;
          end
        end
        S_RD: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RR;
          end
        end
        S_RR: begin
          if (M_AXI_RVALID) begin
            r_rready      <= 1'b0;
            r_resp        <= M_AXI_RRESP;
            r_rdata       <= M_AXI_RDATA;
            r_rsp_timeout <= w_to_hit;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rdata;
  assign rsp_resp      = r_resp;
  assign rsp_timeout   = r_rsp_timeout;
  assign proto_err     = r_proto_err;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: behavioural register slave with programmable stalls,
// scoreboard of expected completions, directed steps in one initial block.
module tb_axil_cmd_master;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout, proto_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [6:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  axil_cmd_master #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) u_dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .proto_err(proto_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] ref_mem [32];
  logic [31:0] mem [32];

  // Slave behaviour knobs
  int   aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic early_b = 1'b0;

  // Slave internal state
  logic        got_aw, got_w, got_ar, b_hs, r_hs, early_fired;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic [6:0]  aw_addr, ar_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register slave: decides its outputs mid-cycle from the master's registered outputs
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        got_aw = 0; got_w = 0; got_ar = 0; b_hs = 0; r_hs = 0; early_fired = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_addr = 0; ar_addr = 0; w_data = 0; w_strb = 0;
      end else begin
        if (b_hs) begin
          if (got_aw && got_w)
            for (int i = 0; i < 4; i++)
              if (w_strb[i]) mem[aw_addr[6:2]][8*i +: 8] = w_data[8*i +: 8];
          M_AXI_BVALID = 0; got_aw = 0; got_w = 0; b_cnt = 0; b_hs = 0; early_fired = 0;
        end
        if (got_aw && got_w && !M_AXI_BVALID) begin
          if (b_cnt >= b_delay) begin M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00; end
          else b_cnt++;
        end
        if (early_b && !early_fired && M_AXI_AWVALID) begin
          M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00; early_fired = 1;
        end
        M_AXI_AWREADY = M_AXI_AWVALID && !got_aw && (aw_cnt >= aw_delay);
        if (M_AXI_AWVALID && !got_aw) begin
          if (M_AXI_AWREADY) begin got_aw = 1; aw_addr = M_AXI_AWADDR; aw_cnt = 0; end
          else aw_cnt++;
        end
        M_AXI_WREADY = M_AXI_WVALID && !got_w && (w_cnt >= w_delay);
        if (M_AXI_WVALID && !got_w) begin
          if (M_AXI_WREADY) begin got_w = 1; w_data = M_AXI_WDATA; w_strb = M_AXI_WSTRB; w_cnt = 0; end
          else w_cnt++;
        end
        b_hs = M_AXI_BVALID && M_AXI_BREADY;

        if (r_hs) begin M_AXI_RVALID = 0; got_ar = 0; r_cnt = 0; r_hs = 0; end
        if (got_ar && !M_AXI_RVALID) begin
          if (r_cnt >= r_delay) begin
            M_AXI_RVALID = 1; M_AXI_RDATA = mem[ar_addr[6:2]]; M_AXI_RRESP = 2'b00;
          end else r_cnt++;
        end
        M_AXI_ARREADY = M_AXI_ARVALID && !got_ar && (ar_cnt >= ar_delay);
        if (M_AXI_ARVALID && !got_ar) begin
          if (M_AXI_ARREADY) begin got_ar = 1; ar_addr = M_AXI_ARADDR; ar_cnt = 0; end
          else ar_cnt++;
        end
        r_hs = M_AXI_RVALID && M_AXI_RREADY;
      end
    end
  end

  // Completion monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_mis++;
          $error("FAIL unexpected_rsp: observed=response expected=none pending");
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command, waits (bounded) for acceptance, queues its expected completion
  task automatic send_cmd(input logic we, input logic [6:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic exp_to);
    exp_t e;
    logic hs;
    int   n;
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    hs = 0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 0;
    chk("cmd_accept", 64'(hs), 64'd1);
    e.resp = 2'b00;
    e.to   = exp_to;
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) ref_mem[a[6:2]][8*i +: 8] = d[8*i +: 8];
      e.rdata = 32'h0;
    end else begin
      e.rdata = ref_mem[a[6:2]];
    end
    sb.push_back(e);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("rsp_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({cmd_ready, rsp_valid, rsp_resp, rsp_timeout, proto_err,
                             M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                             M_AXI_RREADY}), 64'd0);
    chk({tag, "_data"}, {rsp_rdata, M_AXI_WDATA}, 64'd0);
    chk({tag, "_addr"}, 64'({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB}), 64'd0);
  endtask

  initial begin
    logic bready_ok;
    for (int i = 0; i < 32; i++) begin ref_mem[i] = 32'h0; mem[i] = 32'h0; end
    rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 1;
    repeat (3) step();
    chk_all_zero("reset");
    chk("prot", 64'({M_AXI_AWPROT, M_AXI_ARPROT}), 64'd0);
    rst = 0;
    step();
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    // Best-case write with an always-ready slave
    send_cmd(1'b1, 7'h40, 32'h8000_0000, 4'b1000, 1'b0);
    chk("wr_c1_awvalid", 64'(M_AXI_AWVALID), 64'd1);
    chk("wr_c1_wvalid", 64'(M_AXI_WVALID), 64'd1);
    chk("wr_c1_payload", {25'd0, M_AXI_AWADDR, M_AXI_WDATA}, {25'd0, 7'h40, 32'h8000_0000});
    chk("wr_c1_wstrb", 64'(M_AXI_WSTRB), 64'h8);
    step();
    chk("wr_c2_aw_w_pulse", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'd0);
    chk("wr_c2_bready", 64'(M_AXI_BREADY), 64'd1);
    step();
    chk("wr_c3_rsp_valid", 64'(rsp_valid), 64'd1);
    step();
    chk("wr_c4_rsp_done", 64'({rsp_valid, cmd_ready}), 64'b01);
    chk("slv_reg16", 64'(mem[16]), 64'h8000_0000);
    wait_rsp();

    // Read back with the consumer stalling the completion
    rsp_ready = 0;
    send_cmd(1'b0, 7'h40, 32'h0, 4'h0, 1'b0);
    chk("rd_c1_arvalid", 64'({M_AXI_ARVALID, M_AXI_ARADDR}), 64'({1'b1, 7'h40}));
    step();
    chk("rd_c2_ar_pulse", 64'({M_AXI_ARVALID, M_AXI_RREADY}), 64'b01);
    step();
    chk("rd_c3_rsp", {31'd0, rsp_valid, rsp_rdata}, {31'd0, 1'b1, 32'h8000_0000});
    chk("rd_rsp_cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (2) begin
      step();
      chk("rd_rsp_hold", {31'd0, rsp_valid, rsp_rdata}, {31'd0, 1'b1, 32'h8000_0000});
    end
    rsp_ready = 1;
    step();
    chk("rd_rsp_released", 64'(rsp_valid), 64'd0);
    wait_rsp();

    // AW accepted two cycles ahead of W
    aw_delay = 0; w_delay = 2;
    send_cmd(1'b1, 7'h44, 32'hDEAD_BEEF, 4'b0101, 1'b0);
    step();
    chk("aww_c2", {30'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WDATA}, {30'd0, 2'b01, 32'hDEAD_BEEF});
    step();
    chk("aww_c3", {30'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WDATA}, {30'd0, 2'b01, 32'hDEAD_BEEF});
    step();
    chk("aww_c4", 64'({M_AXI_WVALID, M_AXI_BREADY}), 64'b01);
    wait_rsp();
    w_delay = 0;
    send_cmd(1'b0, 7'h44, 32'h0, 4'h0, 1'b0);
    wait_rsp();

    // Slave holds off BVALID past the watchdog limit
    b_delay = 20;
    send_cmd(1'b1, 7'h48, 32'h1234_5678, 4'hF, 1'b1);
    bready_ok = 1;
    repeat (18) begin
      step();
      bready_ok = bready_ok & M_AXI_BREADY;
    end
    chk("to_bready_held", 64'(bready_ok), 64'd1);
    wait_rsp();
    b_delay = 0;
    send_cmd(1'b0, 7'h48, 32'h0, 4'h0, 1'b0);
    wait_rsp();

    // BVALID raised while AWVALID first rises, before any handshake
    aw_delay = 2; w_delay = 2; early_b = 1;
    send_cmd(1'b1, 7'h4C, 32'hA5A5_A5A5, 4'hF, 1'b0);
    chk("early_b_c1", 64'({M_AXI_BREADY, proto_err}), 64'b00);
    step();
    chk("early_b_proto_err", 64'(proto_err), 64'd1);
    wait_rsp();
    early_b = 0; aw_delay = 0; w_delay = 0;
    step();
    chk("proto_err_sticky", 64'(proto_err), 64'd1);

    // Reset while waiting in RR
    r_delay = 100;
    send_cmd(1'b0, 7'h44, 32'h0, 4'h0, 1'b0);
    step();
    chk("rr_rready", 64'(M_AXI_RREADY), 64'd1);
    rst = 1;
    step();
    chk_all_zero("rr_reset");
    sb.delete();
    rst = 0;
    r_delay = 0;
    step();
    chk("rr_cmd_ready_after", 64'(cmd_ready), 64'd1);
    repeat (3) step();

    send_cmd(1'b0, 7'h40, 32'h0, 4'h0, 1'b0);
    wait_rsp();
    chk("final_proto_err", 64'(proto_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
